// File: rtl/sram_rr_arbiter_if.sv
// Requester-side and SRAM-side signals of the round-robin SRAM arbiter.
// The slave modport is the arbiter's view; master is the view of the
// requesters plus the SRAM macro that surround it.
interface sram_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 32
);
    // Requester side, flat vectors: requester i owns slice i.
    logic                        enable;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          readWrite;
    logic [NUM_REQ*ADDR_W-1:0]   address;
    logic [NUM_REQ*DATA_W-1:0]   dataIn;
    logic [NUM_REQ*DATA_W-1:0]   dataOut;
    logic [NUM_REQ-1:0]          done;
    logic [NUM_REQ-1:0]          grant;
    logic                        busy;

    // SRAM side.
    logic                        mem_enable;
    logic                        mem_readWrite;
    logic [ADDR_W-1:0]           mem_address;
    logic [DATA_W-1:0]           mem_dataIn;
    logic [DATA_W-1:0]           mem_dataOut;

    modport slave (
        input  enable, req, readWrite, address, dataIn, mem_dataOut,
        output dataOut, done, grant, busy,
        output mem_enable, mem_readWrite, mem_address, mem_dataIn
    );

    modport master (
        output enable, req, readWrite, address, dataIn, mem_dataOut,
        input  dataOut, done, grant, busy,
        input  mem_enable, mem_readWrite, mem_address, mem_dataIn
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port SRAM among NUM_REQ
// requesters. Optionally zero-fills the SRAM after reset, then serves one
// access at a time: IDLE -> ACCESS -> WAIT (READ_LATENCY cycles) -> DONE.
// Every output is a flop.
module sram_rr_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned READ_LATENCY   = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic              clock,
    input logic              reset,
    sram_rr_arbiter_if.slave bus
);

    localparam int unsigned WaitW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    // Pointer starts on the last requester so requester 0 is searched first.
    localparam logic [NUM_REQ-1:0] PtrRst = {1'b1, {(NUM_REQ-1){1'b0}}};

    typedef enum logic [2:0] {StClear, StIdle, StAccess, StWait, StDone} state_e;

    state_e state_q, state_d;

    logic [NUM_REQ-1:0]        done_q, done_d;
    logic [NUM_REQ*DATA_W-1:0] dataout_q, dataout_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic                      busy_q, busy_d;
    logic                      mem_en_q, mem_en_d;
    logic                      mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]         mem_din_q, mem_din_d;
    logic [NUM_REQ-1:0]        ptr_q, ptr_d;      // one-hot, last requester served
    logic [WaitW-1:0]          wait_q, wait_d;

    logic [NUM_REQ-1:0]        pick;
    logic                      pick_vld;
    logic                      clear_last;

    // The last clear write is in flight when the top address is on the bus.
    assign clear_last = mem_en_q && (mem_addr_q == '1);

    // Rotating priority search: first asserted req after the pointer, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                if (ptr_q[j] && !pick_vld && bus.req[(j + k) % NUM_REQ]) begin
                    pick_vld                 = 1'b1;
                    pick[(j + k) % NUM_REQ]  = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? StClear : StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear:  if (clear_last) state_d = StIdle;
            StIdle:   if (bus.enable && pick_vld) state_d = StAccess;
            StAccess: state_d = StWait;
            StWait:   if (wait_q == '0) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        done_d     = '0;
        dataout_d  = dataout_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        mem_en_d   = 1'b0;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ptr_d      = ptr_q;
        wait_d     = wait_q;
        unique case (state_q)
            StClear: begin
                if (clear_last) begin
                    busy_d   = 1'b0;
                    mem_rw_d = 1'b1;
                end else begin
                    // First clear cycle starts from address 0, then one write per cycle.
                    mem_en_d   = 1'b1;
                    mem_rw_d   = 1'b0;
                    mem_din_d  = '0;
                    mem_addr_d = mem_en_q ? mem_addr_q + ADDR_W'(1) : '0;
                end
            end
            StIdle: begin
                grant_d = '0;
                if (bus.enable && pick_vld) begin
                    grant_d  = pick;
                    mem_en_d = 1'b1;
                    // Latch the winner's command; later changes on its inputs are ignored.
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick[i]) begin
                            mem_rw_d   = bus.readWrite[i];
                            mem_addr_d = bus.address[i*ADDR_W +: ADDR_W];
                            mem_din_d  = bus.dataIn[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            StAccess: begin
                wait_d = WaitW'(READ_LATENCY - 1);
            end
            StWait: begin
                if (wait_q == '0) begin
                    done_d = grant_q;
                    ptr_d  = grant_q;
                    if (mem_rw_q) begin
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            if (grant_q[i]) begin
                                dataout_d[i*DATA_W +: DATA_W] = bus.mem_dataOut;
                            end
                        end
                    end
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            StDone: begin
                grant_d = '0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q     <= '0;
            dataout_q  <= '0;
            grant_q    <= '0;
            busy_q     <= CLEAR_ON_RESET;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b1;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ptr_q      <= PtrRst;
            wait_q     <= '0;
        end else begin
            done_q     <= done_d;
            dataout_q  <= dataout_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ptr_q      <= ptr_d;
            wait_q     <= wait_d;
        end
    end

    assign bus.done          = done_q;
    assign bus.dataOut       = dataout_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.mem_enable    = mem_en_q;
    assign bus.mem_readWrite = mem_rw_q;
    assign bus.mem_address   = mem_addr_q;
    assign bus.mem_dataIn    = mem_din_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: small SRAM model with READ_LATENCY pipeline,
// scoreboard queue of expected completions, one task per scenario.
module tb_sram_rr_arbiter;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RL      = 2;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .READ_LATENCY(RL), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // SRAM model: unwritten words read as non-zero garbage until the DUT clears them.
    logic [DATA_W-1:0] sram [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [DATA_W-1:0] rd_pipe [RL];
    always @(posedge clock) begin
        if (reset) begin
            written <= '0;
        end else if (bus.mem_enable && !bus.mem_readWrite) begin
            sram[bus.mem_address]    <= bus.mem_dataIn;
            written[bus.mem_address] <= 1'b1;
        end
        if (bus.mem_enable) begin
            rd_pipe[0] <= written[bus.mem_address] ? sram[bus.mem_address]
                                                   : {16'hA5A5, 12'h000, bus.mem_address};
        end
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_dataOut = rd_pipe[RL-1];

    typedef struct {
        int unsigned       idx;
        bit                rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int unsigned       n_vec  = 0;
    int unsigned       n_fail = 0;
    int unsigned       last_idx = 0;

    task automatic drive(input int unsigned i, input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bus.readWrite[i]                 = rd;
        bus.address[i*ADDR_W +: ADDR_W]  = a;
        bus.dataIn[i*DATA_W +: DATA_W]   = d;
        bus.req[i]                       = 1'b1;
    endtask

    // Push the expected completion for a transaction and update the memory model.
    task automatic push_exp(input int unsigned i, input bit rd, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        exp_t e;
        e.idx  = i;
        e.rd   = rd;
        e.data = rd ? ref_mem[a] : '0;
        if (!rd) ref_mem[a] = d;
        sbq.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit have);
        have   = (sbq.size() != 0);
        e.idx  = 0;
        e.rd   = 1'b0;
        e.data = '0;
        if (have) e = sbq.pop_front();
    endtask

    task automatic wait_done(input int unsigned limit, output int unsigned cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        while (cyc < limit && to) begin
            @(negedge clock);
            cyc++;
            if (bus.done != '0) to = 1'b0;
        end
    endtask

    task automatic test_reset();
        exp_t e; bit have, to; int unsigned cyc; logic [NUM_REQ-1:0] oh;
        reset = 1'b1;
        bus.enable = 1'b1;
        drive(0, 1'b1, 4'h3, '0);
        drive(1, 1'b1, 4'h1, '0);
        drive(2, 1'b1, 4'h2, '0);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        push_exp(0, 1'b1, 4'h3, '0);
        repeat (2) @(negedge clock);
        n_vec++;
        if (bus.done !== '0 || bus.grant !== '0 || bus.mem_enable !== 1'b0 ||
            bus.mem_readWrite !== 1'b1 || bus.mem_address !== '0 || bus.mem_dataIn !== '0 ||
            bus.busy !== 1'b1 || bus.dataOut !== '0) begin
            n_fail++;
            $display("FAIL reset_values: done=%b grant=%b en=%b rw=%b addr=%h din=%h busy=%b, required 0 0 0 1 0 0 1",
                     bus.done, bus.grant, bus.mem_enable, bus.mem_readWrite, bus.mem_address,
                     bus.mem_dataIn, bus.busy);
        end
        reset = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clock);
            n_vec++;
            if (bus.mem_enable !== 1'b1 || bus.mem_readWrite !== 1'b0 ||
                bus.mem_address !== ADDR_W'(k) || bus.mem_dataIn !== '0 ||
                bus.busy !== 1'b1 || bus.grant !== '0) begin
                n_fail++;
                $display("FAIL clear_write[%0d]: en=%b rw=%b addr=%0d din=%h busy=%b grant=%b, required en=1 rw=0 addr=%0d din=0 busy=1 grant=0",
                         k, bus.mem_enable, bus.mem_readWrite, bus.mem_address, bus.mem_dataIn,
                         bus.busy, bus.grant, k);
            end
        end
        @(negedge clock);
        n_vec++;
        if (bus.mem_enable !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== '0) begin
            n_fail++;
            $display("FAIL clear_end: en=%b busy=%b grant=%b, required en=0 busy=0 grant=0",
                     bus.mem_enable, bus.busy, bus.grant);
        end
        @(negedge clock);
        n_vec++;
        if (bus.grant !== 3'b001 || bus.mem_enable !== 1'b1 || bus.mem_address !== 4'h3) begin
            n_fail++;
            $display("FAIL first_grant: grant=%b en=%b addr=%h, required grant=001 en=1 addr=3",
                     bus.grant, bus.mem_enable, bus.mem_address);
        end
        bus.req = 3'b001;
        wait_done(20, cyc, to);
        pop_exp(e, have);
        oh = NUM_REQ'(1) << e.idx;
        n_vec++;
        if (to || !have || bus.done !== oh || bus.dataOut[e.idx*DATA_W +: DATA_W] !== e.data ||
            cyc != RL + 1) begin
            n_fail++;
            $display("FAIL cleared_read: timeout=%b done=%b data=%h cycles=%0d, required done=%b data=%h cycles=%0d",
                     to, bus.done, bus.dataOut[e.idx*DATA_W +: DATA_W], cyc, oh, e.data, RL + 1);
        end
        last_idx = e.idx;
        bus.req = '0;
        @(negedge clock);
        n_vec++;
        if (bus.done !== '0 || bus.grant !== '0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b grant=%b, required 0 0", bus.done, bus.grant);
        end
    endtask

    task automatic test_write_read();
        exp_t e; bit have, to; int unsigned cyc; logic [NUM_REQ-1:0] oh;
        for (int pass = 0; pass < 2; pass++) begin
            drive(1, pass == 1, 4'h5, 32'hDEAD_BEEF);
            push_exp(1, pass == 1, 4'h5, 32'hDEAD_BEEF);
            @(negedge clock);
            n_vec++;
            if (bus.grant !== 3'b010 || bus.mem_enable !== 1'b1 ||
                bus.mem_readWrite !== (pass == 1) || bus.mem_address !== 4'h5 ||
                (pass == 0 && bus.mem_dataIn !== 32'hDEAD_BEEF)) begin
                n_fail++;
                $display("FAIL access_%0d: grant=%b en=%b rw=%b addr=%h din=%h, required grant=010 en=1 rw=%0d addr=5 din=deadbeef",
                         pass, bus.grant, bus.mem_enable, bus.mem_readWrite, bus.mem_address,
                         bus.mem_dataIn, pass);
            end
            // Changing inputs after the grant must not affect the access.
            bus.address[1*ADDR_W +: ADDR_W] = 4'hA;
            bus.dataIn[1*DATA_W +: DATA_W]  = 32'h1234_5678;
            wait_done(20, cyc, to);
            pop_exp(e, have);
            oh = NUM_REQ'(1) << e.idx;
            n_vec++;
            if (to || !have || bus.done !== oh ||
                (e.rd && bus.dataOut[e.idx*DATA_W +: DATA_W] !== e.data) || cyc != RL + 1) begin
                n_fail++;
                $display("FAIL wr_rd_done_%0d: timeout=%b done=%b data=%h cycles=%0d, required done=%b data=%h cycles=%0d",
                         pass, to, bus.done, bus.dataOut[e.idx*DATA_W +: DATA_W], cyc, oh,
                         e.data, RL + 1);
            end
            last_idx = e.idx;
            bus.req = '0;
            @(negedge clock);
            n_vec++;
            if (bus.done !== '0) begin
                n_fail++;
                $display("FAIL wr_rd_pulse_%0d: done=%b, required 000", pass, bus.done);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e; bit have, to; int unsigned cyc; logic [NUM_REQ-1:0] oh;
        logic [ADDR_W-1:0] rr_addr [NUM_REQ];
        int unsigned nxt;
        rr_addr[0] = 4'h5; rr_addr[1] = 4'h3; rr_addr[2] = 4'h7;
        for (int unsigned i = 0; i < NUM_REQ; i++) drive(i, 1'b1, rr_addr[i], '0);
        for (int unsigned n = 0; n < 4; n++) begin
            nxt = (last_idx + 1 + n) % NUM_REQ;
            push_exp(nxt, 1'b1, rr_addr[nxt], '0);
        end
        for (int n = 0; n < 4; n++) begin
            wait_done(20, cyc, to);
            pop_exp(e, have);
            oh = NUM_REQ'(1) << e.idx;
            n_vec++;
            if (to || !have || bus.done !== oh || bus.grant !== oh ||
                bus.dataOut[e.idx*DATA_W +: DATA_W] !== e.data ||
                cyc != ((n == 0) ? RL + 2 : RL + 3)) begin
                n_fail++;
                $display("FAIL rr_%0d: timeout=%b done=%b grant=%b data=%h cycles=%0d, required done=%b data=%h cycles=%0d",
                         n, to, bus.done, bus.grant, bus.dataOut[e.idx*DATA_W +: DATA_W], cyc,
                         oh, e.data, (n == 0) ? RL + 2 : RL + 3);
            end
            last_idx = e.idx;
        end
        bus.req = '0;
        @(negedge clock);
    endtask

    task automatic test_priority();
        exp_t e; bit have, to; int unsigned cyc; logic [NUM_REQ-1:0] oh;
        drive(2, 1'b0, 4'h9, 32'hCAFE_F00D);
        push_exp(2, 1'b0, 4'h9, 32'hCAFE_F00D);
        @(negedge clock);
        drive(0, 1'b1, 4'h9, '0);
        push_exp(0, 1'b1, 4'h9, '0);
        push_exp(2, 1'b0, 4'h9, 32'hCAFE_F00D);
        for (int n = 0; n < 3; n++) begin
            wait_done(20, cyc, to);
            pop_exp(e, have);
            oh = NUM_REQ'(1) << e.idx;
            n_vec++;
            if (to || !have || bus.done !== oh ||
                (e.rd && bus.dataOut[e.idx*DATA_W +: DATA_W] !== e.data)) begin
                n_fail++;
                $display("FAIL prio_%0d: timeout=%b done=%b data=%h, required done=%b data=%h",
                         n, to, bus.done, bus.dataOut[e.idx*DATA_W +: DATA_W], oh, e.data);
            end
            last_idx = e.idx;
            if (n == 1) bus.req[0] = 1'b0;
            if (n == 2) bus.req[2] = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic test_enable_mid();
        exp_t e; bit have, to; int unsigned cyc; logic [NUM_REQ-1:0] oh;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) drive(1, 1'b1, 4'h5, '0);
            push_exp(1, 1'b1, 4'h5, '0);
            @(negedge clock);
            n_vec++;
            if (bus.grant !== 3'b010) begin
                n_fail++;
                $display("FAIL en_grant_%0d: grant=%b, required 010", pass, bus.grant);
            end
            if (pass == 0) bus.enable = 1'b0;
            wait_done(20, cyc, to);
            pop_exp(e, have);
            oh = NUM_REQ'(1) << e.idx;
            n_vec++;
            if (to || !have || bus.done !== oh ||
                bus.dataOut[e.idx*DATA_W +: DATA_W] !== e.data || cyc != RL + 1) begin
                n_fail++;
                $display("FAIL en_done_%0d: timeout=%b done=%b data=%h cycles=%0d, required done=%b data=%h cycles=%0d",
                         pass, to, bus.done, bus.dataOut[e.idx*DATA_W +: DATA_W], cyc, oh,
                         e.data, RL + 1);
            end
            last_idx = e.idx;
            if (pass == 0) begin
                // Request stays high but no new grant while disabled.
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    n_vec++;
                    if (bus.grant !== '0 || bus.mem_enable !== 1'b0) begin
                        n_fail++;
                        $display("FAIL en_low_hold[%0d]: grant=%b en=%b, required 000 0",
                                 k, bus.grant, bus.mem_enable);
                    end
                end
                bus.enable = 1'b1;
            end
        end
        bus.req = '0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        exp_t e; bit have, to; int unsigned cyc; logic [NUM_REQ-1:0] oh;
        drive(1, 1'b1, 4'h3, '0);
        push_exp(1, 1'b1, 4'h3, '0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.grant !== '0 || bus.done !== '0 || bus.mem_enable !== 1'b0 ||
            bus.busy !== 1'b1 || bus.dataOut !== '0) begin
            n_fail++;
            $display("FAIL async_reset: grant=%b done=%b en=%b busy=%b, required 000 000 0 1",
                     bus.grant, bus.done, bus.mem_enable, bus.busy);
        end
        sbq.delete();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        bus.enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clock);
            n_vec++;
            if (bus.mem_enable !== 1'b1 || bus.mem_address !== ADDR_W'(k) || bus.done !== '0) begin
                n_fail++;
                $display("FAIL reclear[%0d]: en=%b addr=%0d done=%b, required en=1 addr=%0d done=000",
                         k, bus.mem_enable, bus.mem_address, bus.done, k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_vec++;
            if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_en_low[%0d]: grant=%b done=%b busy=%b, required 000 000 0",
                         k, bus.grant, bus.done, bus.busy);
            end
        end
        bus.enable = 1'b1;
        push_exp(1, 1'b1, 4'h3, '0);
        @(negedge clock);
        n_vec++;
        if (bus.grant !== 3'b010) begin
            n_fail++;
            $display("FAIL rst_grant: grant=%b, required 010", bus.grant);
        end
        wait_done(20, cyc, to);
        pop_exp(e, have);
        oh = NUM_REQ'(1) << e.idx;
        n_vec++;
        if (to || !have || bus.done !== oh ||
            bus.dataOut[e.idx*DATA_W +: DATA_W] !== e.data || cyc != RL + 1) begin
            n_fail++;
            $display("FAIL rst_read: timeout=%b done=%b data=%h cycles=%0d, required done=%b data=%h cycles=%0d",
                     to, bus.done, bus.dataOut[e.idx*DATA_W +: DATA_W], cyc, oh, e.data, RL + 1);
        end
        bus.req = '0;
        @(negedge clock);
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.req       = '0;
        bus.readWrite = '1;
        bus.address   = '0;
        bus.dataIn    = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_priority();
        test_enable_mid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-port SRAM among NUM_REQ requesters over a req/done handshake.
- Zero-fills the whole SRAM after reset before accepting requests.
- Issues one access at a time and waits the SRAM read latency before returning data.
- Sits between the CPU/peripheral datapath masters and the sram instance, replacing fixed-priority sequencing.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 15, SRAM address width; depth = 2^ADDR_W
DATA_W, 32, SRAM data width
READ_LATENCY, 2, cycles from the mem_enable cycle to valid mem_dataOut (>=1)
CLEAR_ON_RESET, 1, 1 = zero-fill all addresses after reset; 0 = go straight to IDLE

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  arbitration enable; low = no new grants
req  in  NUM_REQ  per-requester request, held until its done
readWrite  in  NUM_REQ  per requester: 1 = read, 0 = write
address  in  NUM_REQ*ADDR_W  flat; requester i at [i*ADDR_W +: ADDR_W]
dataIn  in  NUM_REQ*DATA_W  flat write data
dataOut  out  NUM_REQ*DATA_W  flat read data, registered
done  out  NUM_REQ  one-cycle completion pulse per requester
grant  out  NUM_REQ  one-hot owner of the current transaction, 0 when idle
busy  out  1  high during the clear sequence
mem_enable  out  1  to SRAM enable
mem_readWrite  out  1  to SRAM readWrite (0 = write)
mem_address  out  ADDR_W  to SRAM address
mem_dataIn  out  DATA_W  to SRAM dataIn
mem_dataOut  in  DATA_W  from SRAM dataOut

Behaviour:
Reset values (asynchronous, reset high):
- done=0, dataOut=0, grant=0, mem_enable=0, mem_readWrite=1, mem_address=0, mem_dataIn=0.
- busy=CLEAR_ON_RESET; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- state=CLEAR if CLEAR_ON_RESET, else IDLE.
- Reset mid-transaction abandons that transaction; no done pulse is produced.

All outputs are registered. States are CLEAR, IDLE, ACCESS, WAIT, DONE.

CLEAR:
- Each cycle: mem_enable=1, mem_readWrite=0, mem_dataIn=0, mem_address = clear counter (0..2^ADDR_W-1, one write per cycle).
- After writing the last address: mem_enable=0, busy=0, go to IDLE.
- req is ignored during CLEAR; requests stay pending.

IDLE:
- mem_enable=0, grant=0.
- If enable and any req: pick the first asserted requester searching from pointer+1 upward, modulo NUM_REQ.
- Latch its readWrite/address/dataIn onto the mem_* outputs, set grant, go to ACCESS.
- If enable is low, stay in IDLE.

ACCESS:
- mem_enable=1 for exactly one cycle, go to WAIT.

WAIT:
- mem_enable=0; lasts READ_LATENCY cycles (down-counter).
- At the edge ending the last WAIT cycle:
  - read: dataOut[g] <= mem_dataOut.
  - write: dataOut[g] is unchanged.
  - done[g] <= 1, pointer <= g, go to DONE.

DONE:
- done[g]=1 for exactly this cycle.
- Next edge: done=0, grant=0, go to IDLE.
- The requester must drop req in its done cycle. A req still high when IDLE is re-entered counts as a new request.

Latency and ordering:
- req sampled in IDLE at cycle t: ACCESS at t+1, done at t+2+READ_LATENCY.
- One transaction takes READ_LATENCY+3 cycles.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,2,0,...; no requester waits more than NUM_REQ-1 transactions.

Edge cases:
- req dropped mid-transaction: the transaction still completes and done pulses.
- enable dropped mid-transaction: the in-flight transaction completes; no new grant is issued.
- Simultaneous requests: resolved in a single cycle by the rr pointer; the other requests stay pending.
- Address/data changes after grant: ignored; the values latched at grant are used.

Test Plan:
- Reset release with ADDR_W=4, CLEAR_ON_RESET=1, all req=1 -> 16 consecutive zero-writes at addresses 0..15, busy high 16 cycles, then first grant=3'b001.
- Requester 1 writes 0xDEADBEEF to address 0x0005, then reads 0x0005 -> done[1] pulses one cycle each, dataOut[1]=0xDEADBEEF, done at t+4 with READ_LATENCY=2.
- req=3'b111 held continuously -> grant sequence 001,010,100,001; each done one cycle; transactions 5 cycles apart.
- Requester 2 active when requester 0 asserts; after requester 2's done, req0 and req2 both high -> requester 0 wins; then req2 wins.
- Reset asserted during WAIT -> outputs zero immediately, no done, CLEAR restarts; with enable=0 after reset, req=3'b010 is held with no grant until enable=1.
- Read of never-written address 0x0003 after clear -> dataOut=0x00000000.
